sram_io_sequencer: RTL

Memory-side sequencer between the LC-3 control unit/datapath and the board SRAM plus memory-mapped I/O. Accepts single-word read/write requests (MAR address, MDR data), runs a fixed-length multi-cycle SRAM access with correct active-low strobes, services address `IO_ADDR` from switches/hex register instead of SRAM, and returns read data with a one-cycle `Done` pulse. The control unit can then wait on `Done` instead of hard-coding access states.

---
 rtl/sram_io_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/sram_io_sequencer.sv
// Sequences single-word LC-3 memory requests onto the board SRAM or the
// memory-mapped switch/hex port, returning a one-cycle Done pulse.
module sram_io_sequencer #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Rd,
  input  logic        Req_Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  input  logic [15:0] Switches,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] Rdata,
  output logic        Done,
  output logic        Busy,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_ACC,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic       accept_rd;
  logic       accept_wr;
  logic       is_io;

  // Read wins when both requests arrive together.
  assign is_io     = (Addr == IO_ADDR);
  assign accept_rd = (state == IDLE) && Req_Rd;
  assign accept_wr = (state == IDLE) && !Req_Rd && Req_Wr;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Req_Rd)      state_next = is_io ? DONE : RD_ACC;
        else if (Req_Wr) state_next = is_io ? DONE : WR_ACC;
      end
      RD_ACC:  if (count == 4'd0) state_next = DONE;
      WR_ACC:  if (count == 4'd0) state_next = WR_HOLD;
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count       <= 4'd0;
      Rdata       <= 16'h0000;
      HEX_Data    <= 16'h0000;
      SRAM_ADDR   <= 20'h00000;
      SRAM_DQ_out <= 16'h0000;
    end else begin
      if (accept_rd || accept_wr) begin
        count       <= CNT_INIT;
        SRAM_ADDR   <= {4'b0000, Addr};
        SRAM_DQ_out <= Wdata;
      end
      if (accept_rd && is_io) Rdata    <= Switches;
      if (accept_wr && is_io) HEX_Data <= Wdata;
      // Counter parks at zero, so it can never wrap during an access.
      if ((state == RD_ACC || state == WR_ACC) && count != 4'd0)
        count <= count - 4'd1;
      if (state == RD_ACC && count == 4'd0)
        Rdata <= SRAM_DQ_in;
    end
  end

  // Strobes decode straight from the state register so requests never reach them.
  assign Done       = (state == DONE);
  assign Busy       = (state != IDLE);
  assign SRAM_CE_N  = !(state == RD_ACC || state == WR_ACC || state == WR_HOLD);
  assign SRAM_UB_N  = !(state == RD_ACC || state == WR_ACC);
  assign SRAM_LB_N  = !(state == RD_ACC || state == WR_ACC);
  assign SRAM_OE_N  = !(state == RD_ACC);
  assign SRAM_WE_N  = !(state == WR_ACC);
  assign SRAM_DQ_oe = (state == WR_ACC || state == WR_HOLD);

endmodule
